inst_encoder: RTL and testbench

- Encoder side of the instruction-word interface consumed by the main-path control decoder.
- Accepts symbolic instructions (op + register fields + immediate) over a valid/ready stream and packs each into a 32-bit MIPS word.
- Writes the encoded words sequentially into instruction memory.
- Used by the program loader and self-test harness to fill instruction memory before the core is released from reset.

---
 rtl/mips_pkg.sv | 64 ++++++
 rtl/inst_field_encode.sv | 35 +++
 rtl/inst_encoder.sv | 122 ++++++++++++
 tb/tb_inst_encoder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS instruction-word definitions for the encoder and the control decoder.
package mips_pkg;

    // Symbolic operation codes carried on the encoder input stream.
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_LW   = 4'd6,
        OP_SW   = 4'd7,
        OP_ADDI = 4'd8,
        OP_BEQ  = 4'd9
    } op_e;

    // Primary opcodes (instruction bits [31:26]).
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;

    // R-type function codes (instruction bits [5:0]).
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;

    // Canonical no-op word; also written in place of illegal ops.
    localparam logic [31:0] NOP_WORD = '0;

    // Load-session controller states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } enc_state_e;

    // Pack an R-type word: {opcode, rs, rt, rd, shamt, funct}.
    function automatic logic [31:0] rtype_word(
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic [4:0] rd,
        input logic [5:0] funct
    );
        return {OPC_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    // Pack an I-type word: {opcode, rs, rt, imm}.
    function automatic logic [31:0] itype_word(
        input logic [5:0]  opc,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm
    );
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/inst_field_encode.sv
// Combinational packer: symbolic op plus register fields into one 32-bit MIPS word.
module inst_field_encode (
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);
    import mips_pkg::*;

    // Select the encoding format by op; unknown ops yield NOP_WORD and flag illegal.
    always_comb begin
        word    = NOP_WORD;
        illegal = 1'b0;
        case (op)
            OP_NOP:  word = NOP_WORD;
            OP_ADD:  word = rtype_word(rs, rt, rd, FUNCT_ADD);
            OP_SUB:  word = rtype_word(rs, rt, rd, FUNCT_SUB);
            OP_AND:  word = rtype_word(rs, rt, rd, FUNCT_AND);
            OP_OR:   word = rtype_word(rs, rt, rd, FUNCT_OR);
            OP_XOR:  word = rtype_word(rs, rt, rd, FUNCT_XOR);
            OP_LW:   word = itype_word(OPC_LW, rs, rt, imm);
            OP_SW:   word = itype_word(OPC_SW, rs, rt, imm);
            OP_ADDI: word = itype_word(OPC_ADDI, rs, rt, imm);
            OP_BEQ:  word = itype_word(OPC_BEQ, rs, rt, imm);
            default: begin
                word    = NOP_WORD;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction-memory loader: accepts symbolic instructions on a valid/ready
// stream, encodes them and writes them to consecutive word addresses.
// MAX_WORDS must not exceed 2**ADDR_W so the address counter never wraps.
module inst_encoder #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   prog_len
);
    import mips_pkg::*;

    localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W + 1)'(MAX_WORDS);

    enc_state_e        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              err_q, err_d;

    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              accept;
    logic [ADDR_W:0]   cnt_inc;
    logic              final_acc;

    inst_field_encode u_enc (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    assign in_ready   = (state_q == ST_LOAD);
    assign accept     = in_valid & in_ready;
    assign cnt_inc    = cnt_q + CNT_ONE;
    assign final_acc  = in_last | (cnt_inc == CNT_MAX);

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign err        = err_q;
    assign prog_len   = cnt_q;
    assign done       = (state_q == ST_DONE);

    // Next-state, write-register capture and session bookkeeping.
    // After the final accept the FSM spends the write cycle in FLUSH and one
    // settle cycle in DRAIN, so done rises two cycles after the last write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    addr_d  = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = enc_word;
                    cnt_d   = cnt_inc;
                    err_d   = err_q | enc_illegal;
                    if (final_acc) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder (default depth plus a 4-word cap instance).
module tb_inst_encoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic        in_last;

    logic        in_ready, imem_we, done, err;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  prog_len;

    logic        cap_in_ready, cap_we, cap_done, cap_err;
    logic [7:0]  cap_addr;
    logic [31:0] cap_wdata;
    logic [8:0]  cap_prog_len;

    int n_checks = 0;
    int n_pass   = 0;

    inst_encoder #(.ADDR_W(8), .MAX_WORDS(256)) u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .done(done), .err(err), .prog_len(prog_len)
    );

    inst_encoder #(.ADDR_W(8), .MAX_WORDS(4)) u_cap (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(cap_in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_last(in_last), .imem_we(cap_we), .imem_addr(cap_addr),
        .imem_wdata(cap_wdata), .done(cap_done), .err(cap_err), .prog_len(cap_prog_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Write logs, recorded on the falling edge.
    logic [31:0] wr_data [0:127];
    logic [7:0]  wr_addr [0:127];
    int          wr_cnt = 0;
    logic [7:0]  cw_addr [0:127];
    int          cw_cnt = 0;
    logic        prev_acc = 1'b0;
    logic        cap_prev_acc = 1'b0;

    // A write must appear exactly in the cycle after each accept, and only then.
    always @(negedge clk) begin
        check_eq("we_latency", 32'(imem_we), 32'(prev_acc));
        check_eq("cap_we_latency", 32'(cap_we), 32'(cap_prev_acc));
        if (imem_we === 1'b1 && wr_cnt < 128) begin
            wr_data[wr_cnt] <= imem_wdata;
            wr_addr[wr_cnt] <= imem_addr;
            wr_cnt          <= wr_cnt + 1;
        end
        if (cap_we === 1'b1 && cw_cnt < 128) begin
            cw_addr[cw_cnt] <= cap_addr;
            cw_cnt          <= cw_cnt + 1;
        end
        prev_acc     <= in_valid & in_ready & ~rst;
        cap_prev_acc <= in_valid & cap_in_ready & ~rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic last);
        int n;
        in_op    = op;
        in_rs    = rs;
        in_rt    = rt;
        in_rd    = rd;
        in_imm   = imm;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) check_eq("ready_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int cycles);
        in_valid = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(done), 32'd1);
    endtask

    logic [31:0] exp_w [0:4];
    int base;

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_op = '0;
        in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_last = 1'b0;
        tick(); tick();
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        check_eq("rst_we", 32'(imem_we), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_addr", 32'(imem_addr), 32'd0);
        check_eq("rst_wdata", imem_wdata, 32'd0);
        check_eq("rst_len", 32'(prog_len), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("idle_ready", 32'(in_ready), 32'd0);

        // Stream encoding, back-to-back.
        base = wr_cnt;
        pulse_start();
        check_eq("load_ready", 32'(in_ready), 32'd1);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0);
        send(4'd6, 5'd29, 5'd8, 5'd0, 16'h0004, 1'b0);
        send(4'd7, 5'd29, 5'd8, 5'd0, 16'h0000, 1'b0);
        send(4'd8, 5'd0, 5'd5, 5'd0, 16'h0007, 1'b0);
        send(4'd9, 5'd1, 5'd2, 5'd0, 16'hFFFF, 1'b1);
        check_eq("s1_last_we", 32'(imem_we), 32'd1);
        check_eq("s1_last_addr", 32'(imem_addr), 32'd4);
        check_eq("s1_last_ready", 32'(in_ready), 32'd0);
        check_eq("s1_done_early0", 32'(done), 32'd0);
        tick();
        check_eq("s1_done_early1", 32'(done), 32'd0);
        tick();
        check_eq("s1_done", 32'(done), 32'd1);
        check_eq("s1_len", 32'(prog_len), 32'd5);
        check_eq("s1_err", 32'(err), 32'd0);
        exp_w[0] = 32'h00221820; exp_w[1] = 32'h8FA80004; exp_w[2] = 32'hAFA80000;
        exp_w[3] = 32'h20050007; exp_w[4] = 32'h1022FFFF;
        check_eq("s1_count", 32'(wr_cnt - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_eq("s1_addr", 32'(wr_addr[base + i]), 32'(i));
            check_eq("s1_data", wr_data[base + i], exp_w[i]);
        end

        // Gaps in the stream; start from DONE.
        base = wr_cnt;
        pulse_start();
        check_eq("s2_done_clr", 32'(done), 32'd0);
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h1234, 1'b0);
        idle(2);
        send(4'd4, 5'd4, 5'd5, 5'd6, 16'h0000, 1'b0);
        idle(1);
        send(4'd5, 5'd7, 5'd8, 5'd9, 16'h0000, 1'b0);
        send(4'd2, 5'd10, 5'd11, 5'd12, 16'h0000, 1'b0);
        idle(3);
        send(4'd3, 5'd31, 5'd31, 5'd31, 16'hFFFF, 1'b1);
        wait_done("s2_done");
        exp_w[0] = 32'h00221820; exp_w[1] = 32'h00853025; exp_w[2] = 32'h00E84826;
        exp_w[3] = 32'h014B6022; exp_w[4] = 32'h03FFF824;
        check_eq("s2_count", 32'(wr_cnt - base), 32'd5);
        for (int i = 0; i < 5; i++) begin
            check_eq("s2_addr", 32'(wr_addr[base + i]), 32'(i));
            check_eq("s2_data", wr_data[base + i], exp_w[i]);
        end
        check_eq("s2_err", 32'(err), 32'd0);
        check_eq("s2_len", 32'(prog_len), 32'd5);

        // Illegal op mid-stream.
        base = wr_cnt;
        pulse_start();
        send(4'd0, 5'd3, 5'd4, 5'd5, 16'hABCD, 1'b0);
        send(4'd12, 5'd31, 5'd31, 5'd31, 16'hFFFF, 1'b0);
        check_eq("s3_err_now", 32'(err), 32'd1);
        check_eq("s3_ill_word", imem_wdata, 32'h00000000);
        send(4'd8, 5'd3, 5'd4, 5'd0, 16'h8000, 1'b0);
        send(4'd6, 5'd0, 5'd1, 5'd0, 16'h0010, 1'b1);
        wait_done("s3_done");
        check_eq("s3_err_hold", 32'(err), 32'd1);
        check_eq("s3_len", 32'(prog_len), 32'd4);
        check_eq("s3_count", 32'(wr_cnt - base), 32'd4);
        check_eq("s3_w0", wr_data[base + 0], 32'h00000000);
        check_eq("s3_w1", wr_data[base + 1], 32'h00000000);
        check_eq("s3_w2", wr_data[base + 2], 32'h20648000);
        check_eq("s3_w3", wr_data[base + 3], 32'h8C010010);
        check_eq("s3_a3", 32'(wr_addr[base + 3]), 32'd3);

        // Start in DONE clears err/len/done; illegal op with last still ends the session.
        base = wr_cnt;
        pulse_start();
        check_eq("s3b_err_clr", 32'(err), 32'd0);
        check_eq("s3b_len_clr", 32'(prog_len), 32'd0);
        check_eq("s3b_done_clr", 32'(done), 32'd0);
        send(4'd15, 5'd1, 5'd1, 5'd1, 16'h0001, 1'b1);
        wait_done("s3b_done");
        check_eq("s3b_len", 32'(prog_len), 32'd1);
        check_eq("s3b_err", 32'(err), 32'd1);
        check_eq("s3b_word", wr_data[base], 32'h00000000);

        // Word cap on the 4-word instance: six words without last.
        base = cw_cnt;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            send(4'd1, 5'd1, 5'd2, 5'(i), 16'h0000, 1'b0);
            if (i == 3) begin
                check_eq("cap_ready_drop", 32'(cap_in_ready), 32'd0);
                check_eq("cap_last_addr", 32'(cap_addr), 32'd3);
            end
        end
        send(4'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 1'b1);
        wait_done("cap_main_done");
        check_eq("cap_done", 32'(cap_done), 32'd1);
        check_eq("cap_len", 32'(cap_prog_len), 32'd4);
        check_eq("cap_count", 32'(cw_cnt - base), 32'd4);
        for (int i = 0; i < 4; i++) check_eq("cap_addr", 32'(cw_addr[base + i]), 32'(i));
        check_eq("cap_main_len", 32'(prog_len), 32'd7);

        // Reset mid-session after two accepts.
        pulse_start();
        send(4'd1, 5'd1, 5'd1, 5'd1, 16'h0000, 1'b0);
        send(4'd1, 5'd2, 5'd2, 5'd2, 16'h0000, 1'b0);
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        check_eq("mrst_we", 32'(imem_we), 32'd0);
        check_eq("mrst_ready", 32'(in_ready), 32'd0);
        check_eq("mrst_addr", 32'(imem_addr), 32'd0);
        check_eq("mrst_wdata", imem_wdata, 32'd0);
        check_eq("mrst_len", 32'(prog_len), 32'd0);
        check_eq("mrst_done", 32'(done), 32'd0);
        check_eq("mrst_err", 32'(err), 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        base = wr_cnt;
        pulse_start();
        send(4'd8, 5'd0, 5'd5, 5'd0, 16'h0007, 1'b1);
        wait_done("mrst_done2");
        check_eq("mrst_count", 32'(wr_cnt - base), 32'd1);
        check_eq("mrst_addr0", 32'(wr_addr[base]), 32'd0);
        check_eq("mrst_len1", 32'(prog_len), 32'd1);

        // Start while loading is ignored.
        base = wr_cnt;
        pulse_start();
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0);
        send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0);
        pulse_start();
        check_eq("busy_len", 32'(prog_len), 32'd2);
        send(4'd3, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b0);
        send(4'd4, 5'd1, 5'd2, 5'd3, 16'h0000, 1'b1);
        wait_done("busy_done");
        check_eq("busy_count", 32'(wr_cnt - base), 32'd4);
        for (int i = 0; i < 4; i++) check_eq("busy_addr", 32'(wr_addr[base + i]), 32'(i));
        check_eq("busy_len4", 32'(prog_len), 32'd4);

        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
